alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 53 +++++
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundles the two requester channels, the response channels and the shared-ALU
// connection of alu_arbiter; the slave modport is the arbiter's view.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req1_valid;
  logic             req0_ready;
  logic             req1_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req0_op;
  logic [1:0]       req1_op;
  logic             req0_setflags;
  logic             req1_setflags;

  logic             resp0_valid;
  logic             resp1_valid;
  logic [WIDTH-1:0] resp0_result;
  logic [WIDTH-1:0] resp1_result;
  logic [3:0]       resp0_flags;
  logic [3:0]       resp1_flags;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  logic             busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
           req0_op, req1_op, req0_setflags, req1_setflags,
           alu_result, alu_flags,
    output req0_ready, req1_ready,
           resp0_valid, resp1_valid, resp0_result, resp1_result,
           resp0_flags, resp1_flags,
           alu_a, alu_b, alu_control, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
           req0_op, req1_op, req0_setflags, req1_setflags,
           alu_result, alu_flags,
    input  req0_ready, req1_ready,
           resp0_valid, resp1_valid, resp0_result, resp1_result,
           resp0_flags, resp1_flags,
           alu_a, alu_b, alu_control, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation per two cycles: IDLE accepts, EXEC captures the ALU output.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic             sf_q, sf_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic             resp0_valid_q, resp0_valid_d;
  logic             resp1_valid_q, resp1_valid_d;
  logic [WIDTH-1:0] resp0_result_q, resp0_result_d;
  logic [WIDTH-1:0] resp1_result_q, resp1_result_d;
  logic [3:0]       flags0_q, flags0_d;
  logic [3:0]       flags1_q, flags1_d;

  logic             grant;
  logic             accept;

  // Under contention the requester that did not win last time gets the grant.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept = bus.req0_valid || bus.req1_valid;

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    id_d           = id_q;
    sf_d           = sf_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    resp0_valid_d  = 1'b0;
    resp1_valid_d  = 1'b0;
    resp0_result_d = resp0_result_q;
    resp1_result_d = resp1_result_q;
    flags0_d       = flags0_q;
    flags1_d       = flags1_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;

    case (state_q)
      IDLE: begin
        bus.req0_ready = bus.req0_valid && !grant;
        bus.req1_ready = bus.req1_valid && grant;
        if (accept) begin
          state_d = EXEC;
          last_d  = grant;
          id_d    = grant;
          if (grant) begin
            a_d  = bus.req1_a;
            b_d  = bus.req1_b;
            op_d = bus.req1_op;
            sf_d = bus.req1_setflags;
          end else begin
            a_d  = bus.req0_a;
            b_d  = bus.req0_b;
            op_d = bus.req0_op;
            sf_d = bus.req0_setflags;
          end
        end
      end

      EXEC: begin
        state_d = IDLE;
        if (id_q) begin
          resp1_valid_d  = 1'b1;
          resp1_result_d = bus.alu_result;
          if (sf_q) begin
            flags1_d = bus.alu_flags;
          end
        end else begin
          resp0_valid_d  = 1'b1;
          resp0_result_d = bus.alu_result;
          if (sf_q) begin
            flags0_d = bus.alu_flags;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- stage boundary: control, responses and flag registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      id_q           <= 1'b0;
      sf_q           <= 1'b0;
      resp0_valid_q  <= 1'b0;
      resp1_valid_q  <= 1'b0;
      resp0_result_q <= '0;
      resp1_result_q <= '0;
      flags0_q       <= 4'b0000;
      flags1_q       <= 4'b0000;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      id_q           <= id_d;
      sf_q           <= sf_d;
      resp0_valid_q  <= resp0_valid_d;
      resp1_valid_q  <= resp1_valid_d;
      resp0_result_q <= resp0_result_d;
      resp1_result_q <= resp1_result_d;
      flags0_q       <= flags0_d;
      flags1_q       <= flags1_d;
    end
  end

  // ---- stage boundary: latched operands, only meaningful while in EXEC ----
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

  assign bus.busy         = (state_q == EXEC);
  assign bus.alu_a        = (state_q == EXEC) ? a_q : '0;
  assign bus.alu_b        = (state_q == EXEC) ? b_q : '0;
  assign bus.alu_control  = (state_q == EXEC) ? op_q : 2'b00;

  assign bus.resp0_valid  = resp0_valid_q;
  assign bus.resp1_valid  = resp1_valid_q;
  assign bus.resp0_result = resp0_result_q;
  assign bus.resp1_result = resp1_result_q;
  assign bus.resp0_flags  = flags0_q;
  assign bus.resp1_flags  = flags1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table of single operations plus contention, reset-abort
// and back-to-back sequences; responses checked against a per-requester queue.
module tb_alu_arbiter;

  logic clk;
  logic reset;

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: flags {N,Z,C,V}; SUB carry means no borrow; logic ops clear C,V.
  logic [32:0] alu_sum;
  logic [31:0] alu_res;
  logic        alu_c;
  logic        alu_v;
  always_comb begin
    alu_sum = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.alu_control)
      2'b00: begin
        alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        alu_res = alu_sum[31:0];
        alu_c   = alu_sum[32];
        alu_v   = (bus.alu_a[31] == bus.alu_b[31]) && (alu_res[31] != bus.alu_a[31]);
      end
      2'b01: begin
        alu_res = bus.alu_a - bus.alu_b;
        alu_c   = (bus.alu_a >= bus.alu_b);
        alu_v   = (bus.alu_a[31] != bus.alu_b[31]) && (alu_res[31] != bus.alu_a[31]);
      end
      2'b10: alu_res = bus.alu_a & bus.alu_b;
      default: alu_res = bus.alu_a | bus.alu_b;
    endcase
    bus.alu_result = alu_res;
    bus.alu_flags  = {alu_res[31], (alu_res == 32'd0), alu_c, alu_v};
  end

  typedef struct packed {
    logic        id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sf;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [31:0] last_res0, last_res1;
  logic [3:0]  last_flg0, last_flg1;
  exp_t        e0, e1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] res, input logic [3:0] flg);
    exp_t e;
    e.res = res;
    e.flg = flg;
    if (id) q1.push_back(e);
    else    q0.push_back(e);
  endtask

  task automatic drive(input vec_t v, input logic valid);
    if (v.id) begin
      bus.req1_a = v.a; bus.req1_b = v.b; bus.req1_op = v.op;
      bus.req1_setflags = v.sf; bus.req1_valid = valid;
    end else begin
      bus.req0_a = v.a; bus.req0_b = v.b; bus.req0_op = v.op;
      bus.req0_setflags = v.sf; bus.req0_valid = valid;
    end
  endtask

  // Present one request, wait (bounded) for its ready, record the expectation.
  task automatic issue(input vec_t v);
    bit got;
    @(posedge clk); #1;
    drive(v, 1'b1);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = v.id ? bus.req1_ready : bus.req0_ready;
    end
    if (!got) begin
      chk("handshake_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
      push(v.id, v.res, v.flg);
    end
    #1;
    drive(v, 1'b0);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = (q0.size() == 0) && (q1.size() == 0);
    end
    chk("drain", {63'd0, done}, 64'd1);
  endtask

  // Response monitor: pulses pop the queue, otherwise results and flags must hold.
  always @(negedge clk) begin
    if (reset) begin
      q0.delete();
      q1.delete();
      last_res0 = '0; last_res1 = '0;
      last_flg0 = '0; last_flg1 = '0;
    end else begin
      chk("ready_exclusive", {63'd0, bus.req0_ready & bus.req1_ready}, 64'd0);
      if (!bus.busy) begin
        chk("alu_idle_a", bus.alu_a, 64'd0);
        chk("alu_idle_b", bus.alu_b, 64'd0);
        chk("alu_idle_ctl", bus.alu_control, 64'd0);
      end
      if (bus.resp0_valid) begin
        if (q0.size() == 0) begin
          chk("resp0_unexpected", 64'd1, 64'd0);
        end else begin
          e0 = q0.pop_front();
          chk("resp0_result", bus.resp0_result, e0.res);
          chk("resp0_flags", bus.resp0_flags, e0.flg);
          last_res0 = e0.res;
          last_flg0 = e0.flg;
        end
      end else begin
        chk("resp0_hold", bus.resp0_result, last_res0);
        chk("flags0_hold", bus.resp0_flags, last_flg0);
      end
      if (bus.resp1_valid) begin
        if (q1.size() == 0) begin
          chk("resp1_unexpected", 64'd1, 64'd0);
        end else begin
          e1 = q1.pop_front();
          chk("resp1_result", bus.resp1_result, e1.res);
          chk("resp1_flags", bus.resp1_flags, e1.flg);
          last_res1 = e1.res;
          last_flg1 = e1.flg;
        end
      end else begin
        chk("resp1_hold", bus.resp1_result, last_res1);
        chk("flags1_hold", bus.resp1_flags, last_flg1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t tbl[10];
  vec_t v0, v1;

  initial begin
    tbl[0] = '{1'b0, 2'b00, 32'd5,          32'd3,          1'b1, 32'd8,          4'b0000};
    tbl[1] = '{1'b1, 2'b01, 32'h8000_0000,  32'd1,          1'b1, 32'h7FFF_FFFF,  4'b0011};
    tbl[2] = '{1'b1, 2'b01, 32'd3,          32'd3,          1'b0, 32'd0,          4'b0011};
    tbl[3] = '{1'b0, 2'b10, 32'hF0F0_0000,  32'hFF00_0000,  1'b1, 32'hF000_0000,  4'b1000};
    tbl[4] = '{1'b0, 2'b11, 32'd0,          32'd0,          1'b0, 32'd0,          4'b1000};
    tbl[5] = '{1'b1, 2'b00, 32'hFFFF_FFFF,  32'd1,          1'b1, 32'd0,          4'b0110};
    tbl[6] = '{1'b0, 2'b00, 32'h7FFF_FFFF,  32'd1,          1'b1, 32'h8000_0000,  4'b1001};
    tbl[7] = '{1'b1, 2'b01, 32'd1,          32'd2,          1'b1, 32'hFFFF_FFFF,  4'b1000};
    tbl[8] = '{1'b0, 2'b01, 32'h1234_5678,  32'h1234_5678,  1'b1, 32'd0,          4'b0110};
    tbl[9] = '{1'b1, 2'b11, 32'h0000_00F0,  32'h0000_000F,  1'b0, 32'h0000_00FF,  4'b1000};

    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 2'b00; bus.req0_setflags = 1'b0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 2'b00; bus.req1_setflags = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_resp0_valid", bus.resp0_valid, 64'd0);
    chk("rst_resp1_valid", bus.resp1_valid, 64'd0);
    chk("rst_resp0_result", bus.resp0_result, 64'd0);
    chk("rst_resp1_result", bus.resp1_result, 64'd0);
    chk("rst_flags0", bus.resp0_flags, 64'd0);
    chk("rst_flags1", bus.resp1_flags, 64'd0);
    chk("rst_busy", bus.busy, 64'd0);

    // Contention straight out of reset: requester 0 must win first.
    v0 = '{1'b0, 2'b00, 32'd1,   32'd1,   1'b0, 32'd2,   4'b0000};
    v1 = '{1'b1, 2'b11, 32'hF0,  32'h0F,  1'b0, 32'hFF,  4'b0000};
    @(posedge clk); #1;
    drive(v0, 1'b1);
    drive(v1, 1'b1);
    @(negedge clk);
    chk("contend_ready0", bus.req0_ready, 64'd1);
    chk("contend_ready1", bus.req1_ready, 64'd0);
    @(posedge clk);
    push(1'b0, v0.res, v0.flg);
    #1 drive(v0, 1'b0);
    issue(v1);

    // Both held: grants must alternate 0,1,0,1 with an EXEC cycle between each.
    v0 = '{1'b0, 2'b00, 32'd1, 32'd2, 1'b0, 32'd3, 4'b0000};
    v1 = '{1'b1, 2'b00, 32'd4, 32'd4, 1'b0, 32'd8, 4'b0000};
    @(posedge clk); #1;
    drive(v0, 1'b1);
    drive(v1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_ready0", bus.req0_ready, (i % 4 == 0) ? 64'd1 : 64'd0);
      chk("rr_ready1", bus.req1_ready, (i % 4 == 2) ? 64'd1 : 64'd0);
      @(posedge clk);
      if (i % 4 == 0) push(1'b0, v0.res, v0.flg);
      if (i % 4 == 2) push(1'b1, v1.res, v1.flg);
    end
    #1;
    drive(v0, 1'b0);
    drive(v1, 1'b0);
    wait_drain();

    for (int k = 0; k < 10; k++) begin
      issue(tbl[k]);
    end
    wait_drain();

    // Reset while EXEC: the accepted operation must vanish without a pulse.
    v1 = '{1'b1, 2'b00, 32'd10, 32'd20, 1'b1, 32'd30, 4'b0000};
    @(posedge clk); #1;
    drive(v1, 1'b1);
    for (int n = 0; n < 20 && !bus.req1_ready; n++) @(negedge clk);
    chk("abort_ready1", bus.req1_ready, 64'd1);
    @(posedge clk);
    #1;
    drive(v1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_resp0_valid", bus.resp0_valid, 64'd0);
    chk("abort_resp1_valid", bus.resp1_valid, 64'd0);
    chk("abort_resp0_result", bus.resp0_result, 64'd0);
    chk("abort_resp1_result", bus.resp1_result, 64'd0);
    chk("abort_flags0", bus.resp0_flags, 64'd0);
    chk("abort_flags1", bus.resp1_flags, 64'd0);
    chk("abort_busy_clr", bus.busy, 64'd0);
    issue(v1);
    wait_drain();

    // req0 held alone: accepted every other cycle, busy in between.
    v0 = '{1'b0, 2'b00, 32'd2, 32'd2, 1'b1, 32'd4, 4'b0000};
    @(posedge clk); #1;
    drive(v0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_ready0", bus.req0_ready, (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("b2b_busy", bus.busy, (i % 2 == 1) ? 64'd1 : 64'd0);
      @(posedge clk);
      if (i % 2 == 0) push(1'b0, v0.res, v0.flg);
    end
    #1 drive(v0, 1'b0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
